// File: rtl/music_beat_ctrl.sv
// Transport controller: beat index and tone-table enable at a selectable tempo,
// with play/pause/stop/loop. Optional seek is compiled in by MUSIC_CTRL_SEEK_EN.
module music_beat_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BEAT_HZ = 8,
    parameter int LEN     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop,
    input  logic [1:0]  tempo_sel,
    input  logic        seek_fwd,
    input  logic        seek_back,
    output logic [11:0] ibeatNum,
    output logic        en,
    output logic        playing,
    output logic        done,
    output logic [1:0]  o_dbg_state
);
    localparam int P  = CLK_HZ / BEAT_HZ;
    localparam int TW = $clog2(2 * P);
    localparam logic [TW-1:0] PM1_BASE = TW'(P - 1);
    localparam logic [TW-1:0] PM1_FAST = TW'(P / 2 - 1);
    localparam logic [TW-1:0] PM1_SLOW = TW'(2 * P - 1);
    localparam logic [11:0]   LAST     = 12'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t         r_state;
    logic [11:0]    r_beat;
    logic [TW-1:0]  r_tick;
    logic [TW-1:0]  r_pcur_m1;
    logic           r_en;
    logic           r_done;

    logic [TW-1:0]  w_tempo_m1;
    logic           w_boundary;
    logic           w_at_last;
    logic           w_song_end;
    logic [11:0]    w_adv_beat;

    // Tick counter stores Pcur-1 so the boundary test is a plain compare.
    always_comb begin
        w_tempo_m1 = PM1_BASE;
        case (tempo_sel)
            2'b01:   w_tempo_m1 = PM1_FAST;
            2'b10:   w_tempo_m1 = PM1_SLOW;
            default: w_tempo_m1 = PM1_BASE;
        endcase
    end

    assign w_boundary = (r_tick == r_pcur_m1);
    assign w_at_last  = (r_beat == LAST);
    assign w_song_end = w_at_last & ~loop;
    assign w_adv_beat = w_at_last ? 12'd0 : r_beat + 12'd1;

`ifdef MUSIC_CTRL_SEEK_EN
    logic        w_do_fwd;
    logic        w_do_back;
    logic        w_seek;
    logic [12:0] w_fwd_sum;
    logic [11:0] w_seek_beat;

    assign w_do_fwd  = seek_fwd & ~seek_back;
    assign w_do_back = seek_back & ~seek_fwd;
    assign w_seek    = w_do_fwd | w_do_back;
    assign w_fwd_sum = {1'b0, r_beat} + 13'd4;

    always_comb begin
        w_seek_beat = r_beat;
        if (w_do_fwd) begin
            if (w_fwd_sum >= 13'(LEN))
                w_seek_beat = loop ? 12'(w_fwd_sum % 13'(LEN)) : LAST;
            else
                w_seek_beat = w_fwd_sum[11:0];
        end else if (w_do_back) begin
            w_seek_beat = (r_beat < 12'd4) ? 12'd0 : r_beat - 12'd4;
        end
    end
`else
    logic w_unused_seek;
    assign w_unused_seek = seek_fwd ^ seek_back;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_beat    <= 12'd0;
            r_tick    <= '0;
            r_pcur_m1 <= w_tempo_m1;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_beat <= 12'd0;
                    r_tick <= '0;
                    if (!stop && !pause && play) begin
                        r_state   <= S_PLAY;
                        r_pcur_m1 <= w_tempo_m1;
                        r_en      <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_beat  <= 12'd0;
                        r_tick  <= '0;
                        r_en    <= 1'b0;
                    end else if (pause) begin
                        r_en <= 1'b0;
                        // A boundary in the same cycle still advances or ends the song.
                        if (w_boundary && w_song_end) begin
                            r_state <= S_IDLE;
                            r_beat  <= 12'd0;
                            r_tick  <= '0;
                            r_done  <= 1'b1;
                        end else if (w_boundary) begin
                            r_state   <= S_PAUSE;
                            r_beat    <= w_adv_beat;
                            r_tick    <= '0;
                            r_pcur_m1 <= w_tempo_m1;
                        end else begin
                            r_state <= S_PAUSE;
                        end
                    end
`ifdef MUSIC_CTRL_SEEK_EN
                    else if (w_seek) begin
                        r_beat <= w_seek_beat;
                        r_tick <= '0;
                    end
`endif
                    else if (w_boundary) begin
                        r_tick <= '0;
                        if (w_song_end) begin
                            r_state <= S_IDLE;
                            r_beat  <= 12'd0;
                            r_en    <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_beat    <= w_adv_beat;
                            r_pcur_m1 <= w_tempo_m1;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_beat  <= 12'd0;
                        r_tick  <= '0;
                    end else if (play) begin
                        r_state <= S_PLAY;
                        r_en    <= 1'b1;
                    end
`ifdef MUSIC_CTRL_SEEK_EN
                    else if (w_seek) begin
                        r_beat <= w_seek_beat;
                        r_tick <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_beat  <= 12'd0;
                    r_tick  <= '0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign ibeatNum    = r_beat;
    assign en          = r_en;
    assign playing     = r_en;
    assign done        = r_done;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_music_beat_ctrl.sv
// Directed bench for music_beat_ctrl with P=10 cycles per beat and an 8-beat song.
module tb_music_beat_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [1:0]  tempo_sel = 2'b00;
    logic        seek_fwd = 1'b0;
    logic        seek_back = 1'b0;
    logic [11:0] ibeatNum;
    logic        en;
    logic        playing;
    logic        done;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int failures = 0;

    music_beat_ctrl #(.CLK_HZ(80), .BEAT_HZ(8), .LEN(8)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .loop(loop), .tempo_sel(tempo_sel), .seek_fwd(seek_fwd),
        .seek_back(seek_back), .ibeatNum(ibeatNum), .en(en),
        .playing(playing), .done(done), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // One clock: inputs set before the call are sampled at this edge; pulses drop after.
    task automatic cyc();
        @(posedge clk);
        #1;
        play = 1'b0; pause = 1'b0; stop = 1'b0; seek_fwd = 1'b0; seek_back = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n cycles at beat b with enable e and no done pulse.
    task automatic hold(input int n, input int b, input logic e);
        for (int i = 0; i < n; i++) begin
            chk("beat", 32'(ibeatNum), 32'(b));
            chk("en", 32'(en), 32'(e));
            chk("playing", 32'(playing), 32'(e));
            chk("done_low", 32'(done), 32'd0);
            cyc();
        end
    endtask

    task automatic beats(input int first, input int last, input int n);
        for (int b = first; b <= last; b++) hold(n, b, 1'b1);
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_state"}, 32'(o_dbg_state), 32'd0);
        chk({tag, "_beat"}, 32'(ibeatNum), 32'd0);
        chk({tag, "_en"}, 32'(en), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    initial begin
        // reset
        rst = 1'b1; cyc(); cyc();
        chk_idle("reset", 1'b0);
        chk("reset_playing", 32'(playing), 32'd0);
        rst = 1'b0;
        hold(2, 0, 1'b0);
        pause = 1'b1; cyc();
        chk_idle("idle_pause", 1'b0);

        // full song, no loop, base tempo
        play = 1'b1; cyc();
        chk("play_state", 32'(o_dbg_state), 32'd1);
        beats(0, 7, 10);
        chk_idle("song_end", 1'b1);
        cyc();
        chk_idle("after_end", 1'b0);

        // loop at fast tempo: 5 cycles per beat, wraps without done
        loop = 1'b1; tempo_sel = 2'b01;
        play = 1'b1; cyc();
        beats(0, 7, 5);
        beats(0, 1, 5);
        stop = 1'b1; cyc();
        chk_idle("loop_stop", 1'b0);

        // pause at tick 3 of beat 2, resume after 20 cycles
        loop = 1'b0; tempo_sel = 2'b00;
        play = 1'b1; cyc();
        beats(0, 1, 10);
        hold(3, 2, 1'b1);
        pause = 1'b1; cyc();
        for (int i = 0; i < 20; i++) begin
            chk("pause_state", 32'(o_dbg_state), 32'd2);
            chk("pause_beat", 32'(ibeatNum), 32'd2);
            chk("pause_en", 32'(en), 32'd0);
            cyc();
        end
        play = 1'b1; cyc();
        hold(7, 2, 1'b1);
        hold(10, 3, 1'b1);
        stop = 1'b1; cyc();
        chk_idle("pause_stop", 1'b0);

        // stop and play together in beat 5
        play = 1'b1; cyc();
        beats(0, 4, 10);
        hold(4, 5, 1'b1);
        stop = 1'b1; play = 1'b1; cyc();
        chk_idle("stop_play", 1'b0);
        hold(3, 0, 1'b0);

        // stop coincident with the final beat boundary suppresses done
        play = 1'b1; cyc();
        beats(0, 6, 10);
        hold(9, 7, 1'b1);
        stop = 1'b1; cyc();
        chk_idle("stop_at_end", 1'b0);

        // slow tempo selected mid-beat 1 applies from beat 2
        play = 1'b1; cyc();
        hold(10, 0, 1'b1);
        hold(4, 1, 1'b1);
        tempo_sel = 2'b10;
        hold(6, 1, 1'b1);
        hold(20, 2, 1'b1);
        hold(1, 3, 1'b1);
        tempo_sel = 2'b00;
        stop = 1'b1; cyc();
        chk_idle("tempo_stop", 1'b0);

        // reset overrides a same-cycle play
        play = 1'b1; cyc();
        hold(3, 0, 1'b1);
        rst = 1'b1; play = 1'b1; cyc();
        chk_idle("mid_reset", 1'b0);
        rst = 1'b0; cyc();

        // seek forward at beat 6, no loop
        play = 1'b1; cyc();
        beats(0, 5, 10);
        hold(2, 6, 1'b1);
        seek_fwd = 1'b1; cyc();
`ifdef MUSIC_CTRL_SEEK_EN
        hold(10, 7, 1'b1);
`else
        hold(7, 6, 1'b1);
        hold(10, 7, 1'b1);
`endif
        chk_idle("seek_end", 1'b1);
        cyc();

        // seek forward at beat 6 with loop wraps modulo length
        loop = 1'b1;
        play = 1'b1; cyc();
        beats(0, 5, 10);
        hold(2, 6, 1'b1);
        seek_fwd = 1'b1; cyc();
`ifdef MUSIC_CTRL_SEEK_EN
        hold(10, 2, 1'b1);
`else
        hold(7, 6, 1'b1);
        hold(10, 7, 1'b1);
`endif
        stop = 1'b1; cyc();
        chk_idle("seek_loop_stop", 1'b0);
        loop = 1'b0;

        // seek back at beat 1 clamps at 0
        play = 1'b1; cyc();
        hold(10, 0, 1'b1);
        hold(2, 1, 1'b1);
        seek_back = 1'b1; cyc();
`ifdef MUSIC_CTRL_SEEK_EN
        hold(10, 0, 1'b1);
        hold(1, 1, 1'b1);
`else
        hold(7, 1, 1'b1);
        hold(1, 2, 1'b1);
`endif
        stop = 1'b1; cyc();
        chk_idle("seek_back_stop", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
